// File: rtl/rr_arbiter16_pkg.sv
// Shared constants and state encodings for the 16-way round-robin arbiter.
package rr_arbiter16_pkg;
  localparam int N_REQ  = 16;
  localparam int IDX_W  = 4;
  localparam int HOLD_W = 8;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t GRANT = 1'b1;
endpackage

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter16_if;
  import rr_arbiter16_pkg::*;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;

  modport master (output req, input grant, grant_idx, grant_valid);
  modport slave  (input req, output grant, grant_idx, grant_valid);
endinterface

// File: rtl/rr_arbiter16_onehot_decode16.sv
// Enabled 4-to-16 one-hot decoder; output is all zero when disabled.
module onehot_decode16
  import rr_arbiter16_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);
  assign onehot = en ? (N_REQ'(1) << idx) : '0;
endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter over 16 requesters with a bounded grant tenure;
// all outputs are registered.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           reset,
  rr_arbiter16_if.slave  bus
);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_t            state, nxt_state;
  logic [IDX_W-1:0]  ptr, nxt_ptr;
  logic [HOLD_W-1:0] hold_cnt, nxt_cnt;
  logic [IDX_W-1:0]  grant_idx, nxt_idx;
  logic              grant_valid;
  logic [N_REQ-1:0]  grant, nxt_grant;
  logic [N_REQ-1:0]  own, others;

  // First set bit of mask scanning start, start+1, ... modulo 16.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] start,
                                               input logic [N_REQ-1:0] mask);
    logic [IDX_W-1:0] k;
    logic             hit;
    rr_next = '0;
    hit     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = start + IDX_W'(i);
      if (!hit && mask[k]) begin
        rr_next = k;
        hit     = 1'b1;
      end
    end
  endfunction

  assign own    = N_REQ'(1) << grant_idx;
  assign others = bus.req & ~own;

  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_cnt   = hold_cnt;
    nxt_idx   = grant_idx;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          nxt_state = GRANT;
          nxt_idx   = rr_next(ptr + IDX_W'(1), bus.req);
          nxt_ptr   = nxt_idx;
          nxt_cnt   = HOLD_W'(1);
        end
      end
      default: begin
        if (!bus.req[grant_idx]) begin
          // Drop takes precedence over tenure expiry; hand over with no bubble.
          if (|bus.req) begin
            nxt_idx = rr_next(grant_idx + IDX_W'(1), bus.req);
            nxt_ptr = nxt_idx;
            nxt_cnt = HOLD_W'(1);
          end else begin
            nxt_state = IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
          end
        end else if (hold_cnt < HOLD_MAX) begin
          nxt_cnt = hold_cnt + HOLD_W'(1);
        end else if (|others) begin
          nxt_idx = rr_next(grant_idx + IDX_W'(1), others);
          nxt_ptr = nxt_idx;
          nxt_cnt = HOLD_W'(1);
        end
      end
    endcase
  end

  // Decode the value being loaded into grant_idx so grant and grant_idx
  // change on the same edge.
  onehot_decode16 u_dec (
    .en     (nxt_state == GRANT),
    .idx    (nxt_idx),
    .onehot (nxt_grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= {IDX_W{1'b1}};
      hold_cnt    <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      grant       <= '0;
    end else begin
      state       <= nxt_state;
      ptr         <= nxt_ptr;
      hold_cnt    <= nxt_cnt;
      grant_idx   <= nxt_idx;
      grant_valid <= (nxt_state == GRANT);
      grant       <= nxt_grant;
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_idx   = grant_idx;
  assign bus.grant_valid = grant_valid;
endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16: three instances (MAX_HOLD 8, 4, 1) share
// one request vector and reset; each scenario checks the relevant instance.
module tb_rr_arbiter16;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] req = '0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  rr_arbiter16_if bus8 ();
  rr_arbiter16_if bus4 ();
  rr_arbiter16_if bus1 ();
  assign bus8.req = req;
  assign bus4.req = req;
  assign bus1.req = req;

  rr_arbiter16 #(.MAX_HOLD(8)) u8 (.clk(clk), .reset(reset), .bus(bus8));
  rr_arbiter16 #(.MAX_HOLD(4)) u4 (.clk(clk), .reset(reset), .bus(bus4));
  rr_arbiter16 #(.MAX_HOLD(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));

  always @(negedge clk) begin
    assert ($onehot0(bus8.grant));
    assert ($onehot0(bus4.grant));
    assert ($onehot0(bus1.grant));
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Idle after reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_grant", bus8.grant, 16'h0000);
      chk("idle_valid", {15'b0, bus8.grant_valid}, 16'h0000);
      chk("idle_idx", {12'b0, bus8.grant_idx}, 16'h0000);
    end

    // Tenure expiry with two contenders, MAX_HOLD = 8
    req = 16'h8001;
    step();
    chk("t8_first", bus8.grant, 16'h0001);
    chk("t8_first_idx", {12'b0, bus8.grant_idx}, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t8_hold0", bus8.grant, 16'h0001);
    end
    step();
    chk("t8_switch15", bus8.grant, 16'h8000);
    chk("t8_switch15_idx", {12'b0, bus8.grant_idx}, 16'h000f);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t8_hold15", bus8.grant, 16'h8000);
    end
    step();
    chk("t8_wrap0", bus8.grant, 16'h0001);

    // Holder drop: direct handover, then idle
    do_reset();
    req = 16'h0024;
    step();
    chk("drop_first", bus8.grant, 16'h0004);
    req = 16'h0020;
    step();
    chk("drop_handover", bus8.grant, 16'h0020);
    chk("drop_valid", {15'b0, bus8.grant_valid}, 16'h0001);
    req = 16'h0000;
    step();
    chk("drop_idle", bus8.grant, 16'h0000);
    chk("drop_idle_valid", {15'b0, bus8.grant_valid}, 16'h0000);
    chk("drop_idle_idx", {12'b0, bus8.grant_idx}, 16'h0000);

    // Sole requester keeps a saturated grant, MAX_HOLD = 4
    do_reset();
    req = 16'h0100;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("sole_hold", bus4.grant, 16'h0100);
    end
    req = 16'h0102;
    step();
    chk("sole_preempt", bus4.grant, 16'h0002);
    chk("sole_preempt_idx", {12'b0, bus4.grant_idx}, 16'h0001);

    // Reset mid-grant ignores requests, then restarts from ptr = 15
    do_reset();
    req = 16'h0200;
    step();
    chk("mid_grant9", bus8.grant, 16'h0200);
    reset = 1'b1;
    req   = 16'h0210;
    step();
    chk("mid_reset_grant", bus8.grant, 16'h0000);
    chk("mid_reset_valid", {15'b0, bus8.grant_valid}, 16'h0000);
    reset = 1'b0;
    step();
    chk("mid_after", bus8.grant, 16'h0010);

    // Wrap: ptr = 14, only req[3] set
    do_reset();
    req = 16'h4000;
    step();
    chk("wrap_g14", bus8.grant, 16'h4000);
    req = 16'h0000;
    step();
    chk("wrap_idle", bus8.grant, 16'h0000);
    req = 16'h0008;
    step();
    chk("wrap_g3", bus8.grant, 16'h0008);
    chk("wrap_g3_idx", {12'b0, bus8.grant_idx}, 16'h0003);

    // MAX_HOLD = 1 rotates every cycle under full load
    do_reset();
    req = 16'hffff;
    for (int i = 0; i < 17; i++) begin
      logic [15:0] exp_oh;
      exp_oh = 16'h0001 << (i % 16);
      step();
      chk("rot_idx", {12'b0, bus1.grant_idx}, 16'(i % 16));
      chk("rot_grant", bus1.grant, exp_oh);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
